// File: rtl/crop_pkg.sv
// Shared types and default geometry for the crop frame sequencer.
// crop_origin_t is sized for the default frame geometry; the top must not be built wider.
package crop_pkg;
  localparam int IN_ROWS_DEF  = 20;
  localparam int IN_COLS_DEF  = 20;
  localparam int OUT_ROWS_DEF = 10;
  localparam int OUT_COLS_DEF = 10;
  localparam int COL_W = $clog2(IN_COLS_DEF);
  localparam int ROW_W = $clog2(IN_ROWS_DEF);

  typedef enum logic [1:0] {IDLE, START, STREAM, WAIT_DONE} crop_seq_state_t;

  typedef struct packed {
    logic [COL_W-1:0] x0;
    logic [ROW_W-1:0] y0;
  } crop_origin_t;
endpackage

// File: rtl/crop_pos_counter.sv
// Column/row position of the current input beat, with wrap and last-position flag.
module crop_pos_counter #(
  parameter int IN_ROWS = 20,
  parameter int IN_COLS = 20,
  parameter int CW = $clog2(IN_COLS),
  parameter int RW = $clog2(IN_ROWS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          beat,
  output logic [CW-1:0] cnt_col,
  output logic [RW-1:0] cnt_row,
  output logic          at_last
);
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          col_end, row_end;

  assign col_end = (col_q == CW'(IN_COLS - 1));
  assign row_end = (row_q == RW'(IN_ROWS - 1));

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clr) begin
      col_d = '0;
      row_d = '0;
    end else if (beat) begin
      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign cnt_col = col_q;
  assign cnt_row = row_q;
  assign at_last = col_end && row_end;
endmodule

// File: rtl/crop_frame_sequencer.sv
// Frame-level controller for the crop filter: latches a crop origin, pulses ap_start,
// gates the input stream to whole frames, and waits for both done pulses. Option: CROP_SEQ_CLAMP_EN.
module crop_frame_sequencer
  import crop_pkg::*;
#(
  parameter int IN_ROWS  = IN_ROWS_DEF,
  parameter int IN_COLS  = IN_COLS_DEF,
  parameter int OUT_ROWS = OUT_ROWS_DEF,
  parameter int OUT_COLS = OUT_COLS_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [$clog2(IN_COLS)-1:0] cfg_x0,
  input  logic [$clog2(IN_ROWS)-1:0] cfg_y0,
  input  logic                       pix_valid,
  input  logic                       pix_ready,
  output logic                       pix_gate,
  output logic [$clog2(IN_COLS)-1:0] cnt_col,
  output logic [$clog2(IN_ROWS)-1:0] cnt_row,
  output logic [$clog2(IN_COLS)-1:0] crop_x0,
  output logic [$clog2(IN_ROWS)-1:0] crop_y0,
  output logic                       ap_start,
  input  logic                       crop_ap_done,
  input  logic                       seq_ap_done,
  output logic                       busy,
  output logic [15:0]                frame_cnt,
  output logic                       cfg_err
);
  localparam int CW = $clog2(IN_COLS);
  localparam int RW = $clog2(IN_ROWS);

  crop_seq_state_t state_q, state_d;
  crop_origin_t    crop_q, crop_d, pend_q, pend_d, req;
  logic            pend_vld_q, pend_vld_d;
  logic            crop_done_q, crop_done_d, seq_done_q, seq_done_d;
  logic [15:0]     frame_cnt_q, frame_cnt_d;
  logic            cfg_err_q, cfg_err_d;
  logic            beat, at_last, accept, take, req_ok;
  logic            fit_x, fit_y;
  logic [CW:0]     x_end;
  logic [RW:0]     y_end;

  // Widened so the origin+size sum cannot wrap before the compare.
  assign x_end = {1'b0, cfg_x0} + (CW+1)'(OUT_COLS);
  assign y_end = {1'b0, cfg_y0} + (RW+1)'(OUT_ROWS);
  assign fit_x = (x_end <= (CW+1)'(IN_COLS));
  assign fit_y = (y_end <= (RW+1)'(IN_ROWS));

  always_comb begin
`ifdef CROP_SEQ_CLAMP_EN
    req.x0 = fit_x ? COL_W'(cfg_x0) : COL_W'(IN_COLS - OUT_COLS);
    req.y0 = fit_y ? ROW_W'(cfg_y0) : ROW_W'(IN_ROWS - OUT_ROWS);
    req_ok = 1'b1;
`else
    req.x0 = COL_W'(cfg_x0);
    req.y0 = ROW_W'(cfg_y0);
    req_ok = fit_x && fit_y;
`endif
  end

  // The pending slot is always empty in IDLE, so this also covers IDLE's cfg_ready=1.
  assign cfg_ready = !pend_vld_q;
  assign accept    = cfg_valid && cfg_ready;
  assign take      = accept && req_ok;
  assign pix_gate  = (state_q == STREAM);
  assign ap_start  = (state_q == START);
  assign busy      = (state_q != IDLE);
  assign beat      = pix_valid && pix_ready && pix_gate;

  crop_pos_counter #(.IN_ROWS(IN_ROWS), .IN_COLS(IN_COLS), .CW(CW), .RW(RW)) u_pos (
    .clk     (clk),
    .reset   (reset),
    .clr     (state_q == START),
    .beat    (beat),
    .cnt_col (cnt_col),
    .cnt_row (cnt_row),
    .at_last (at_last)
  );

  always_comb begin
    state_d     = state_q;
    crop_d      = crop_q;
    pend_d      = pend_q;
    pend_vld_d  = pend_vld_q;
    crop_done_d = crop_done_q;
    seq_done_d  = seq_done_q;
    frame_cnt_d = frame_cnt_q;
    cfg_err_d   = cfg_err_q | (accept && !(fit_x && fit_y));
    if (take && state_q != IDLE) begin
      pend_d     = req;
      pend_vld_d = 1'b1;
    end
    if (state_q == STREAM || state_q == WAIT_DONE) begin
      crop_done_d = crop_done_q | crop_ap_done;
      seq_done_d  = seq_done_q | seq_ap_done;
    end
    case (state_q)
      IDLE: if (take) begin
        crop_d  = req;
        state_d = START;
      end
      START: begin
        crop_done_d = 1'b0;
        seq_done_d  = 1'b0;
        state_d     = STREAM;
      end
      STREAM: if (beat && at_last) state_d = WAIT_DONE;
      WAIT_DONE: if (crop_done_q && seq_done_q) begin
        frame_cnt_d = frame_cnt_q + 16'd1;
        // A request arriving this very cycle goes straight to the next frame.
        if (pend_vld_q || take) begin
          crop_d     = pend_vld_q ? pend_q : req;
          pend_vld_d = 1'b0;
          state_d    = START;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      crop_q      <= '0;
      pend_q      <= '0;
      pend_vld_q  <= 1'b0;
      crop_done_q <= 1'b0;
      seq_done_q  <= 1'b0;
      frame_cnt_q <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      crop_q      <= crop_d;
      pend_q      <= pend_d;
      pend_vld_q  <= pend_vld_d;
      crop_done_q <= crop_done_d;
      seq_done_q  <= seq_done_d;
      frame_cnt_q <= frame_cnt_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign crop_x0   = CW'(crop_q.x0);
  assign crop_y0   = RW'(crop_q.y0);
  assign frame_cnt = frame_cnt_q;
  assign cfg_err   = cfg_err_q;
endmodule

// File: tb/tb_crop_frame_sequencer.sv
// Directed bench for crop_frame_sequencer: origin latch, full-frame streaming, done
// handshakes, pending request, fit check and mid-frame reset.
module tb_crop_frame_sequencer;
  logic        clk = 1'b0;
  logic        reset, cfg_valid, pix_valid, pix_ready, crop_ap_done, seq_ap_done;
  logic [4:0]  cfg_x0, cfg_y0;
  logic        cfg_ready, pix_gate, ap_start, busy, cfg_err;
  logic [4:0]  cnt_col, cnt_row, crop_x0, crop_y0;
  logic [15:0] frame_cnt;
  int          n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  crop_frame_sequencer dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_x0(cfg_x0), .cfg_y0(cfg_y0), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_gate(pix_gate), .cnt_col(cnt_col), .cnt_row(cnt_row), .crop_x0(crop_x0),
    .crop_y0(crop_y0), .ap_start(ap_start), .crop_ap_done(crop_ap_done),
    .seq_ap_done(seq_ap_done), .busy(busy), .frame_cnt(frame_cnt), .cfg_err(cfg_err)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives n beats from STREAM; done pulses and a cfg request ride on chosen beat indices.
  task automatic stream(input int n, input int seq_at, input int crop_at, input int cfg_at,
                        input logic [4:0] nx, input logic [4:0] ny);
    int   beats = 0;
    int   cyc = 0;
    logic tog = 1'b1;
    logic pend = 1'b0;
    logic b;
    while (beats < n && cyc < 4*n + 20) begin
      chk("gate", pix_gate, 1);
      chk("col", cnt_col, beats % 20);
      chk("row", cnt_row, beats / 20);
      chk("cfg_rdy_strm", cfg_ready, !pend);
      pix_valid    = (cyc % 7 != 3);
      pix_ready    = tog;
      tog          = ~tog;
      b            = pix_valid && pix_ready;
      seq_ap_done  = b && beats == seq_at;
      crop_ap_done = b && beats == crop_at;
      cfg_valid    = b && beats == cfg_at;
      cfg_x0       = nx;
      cfg_y0       = ny;
      tick();
      if (cfg_valid) pend = 1'b1;
      if (b) beats++;
      cyc++;
    end
    pix_valid = 0; pix_ready = 0; seq_ap_done = 0; crop_ap_done = 0; cfg_valid = 0;
    chk("beat_budget", beats, n);
  endtask

  task automatic cfg_req(input logic [4:0] x, input logic [4:0] y);
    cfg_valid = 1; cfg_x0 = x; cfg_y0 = y;
    chk("cfg_rdy_idle", cfg_ready, 1);
    tick();
    cfg_valid = 0;
  endtask

  initial begin
    reset = 1; cfg_valid = 0; pix_valid = 0; pix_ready = 0;
    crop_ap_done = 0; seq_ap_done = 0; cfg_x0 = 0; cfg_y0 = 0;
    tick(); tick();
    reset = 0;
    chk("rst_busy", busy, 0);   chk("rst_cfg_rdy", cfg_ready, 1);
    chk("rst_gate", pix_gate, 0); chk("rst_start", ap_start, 0);
    chk("rst_frames", frame_cnt, 0); chk("rst_err", cfg_err, 0);
    chk("rst_col", cnt_col, 0); chk("rst_x0", crop_x0, 0);

    // Frame 1: origin (3,4); seq done before crop done.
    cfg_req(5'd3, 5'd4);
    chk("f1_start", ap_start, 1); chk("f1_x0", crop_x0, 3); chk("f1_y0", crop_y0, 4);
    chk("f1_gate_early", pix_gate, 0);
    tick();
    chk("f1_start_off", ap_start, 0); chk("f1_gate", pix_gate, 1);
    stream(400, 100, 200, -1, 5'd0, 5'd0);
    chk("f1_gate_after", pix_gate, 0); chk("f1_col0", cnt_col, 0); chk("f1_row0", cnt_row, 0);
    chk("f1_busy_wait", busy, 1); chk("f1_frames_wait", frame_cnt, 0);
    tick();
    chk("f1_frames", frame_cnt, 1); chk("f1_idle", busy, 0); chk("f1_no_start", ap_start, 0);

    // Frame 2: both dones with the last beat; request (0,10) queued mid-frame.
    cfg_req(5'd1, 5'd2);
    tick();
    stream(400, 399, 399, 50, 5'd0, 5'd10);
    chk("f2_x0_hold", crop_x0, 1); chk("f2_y0_hold", crop_y0, 2);
    chk("f2_pend_full", cfg_ready, 0); chk("f2_frames_wait", frame_cnt, 1);
    tick();
    chk("f2_frames", frame_cnt, 2); chk("f2_restart", ap_start, 1);
    chk("f2_new_x0", crop_x0, 0); chk("f2_new_y0", crop_y0, 10); chk("f2_pend_free", cfg_ready, 1);
    tick();
    chk("f3_gate", pix_gate, 1); chk("f3_start_off", ap_start, 0);

    // Frame 3: reset after 137 beats with a pending request outstanding.
    stream(137, -1, -1, 10, 5'd5, 5'd5);
    chk("f3_col", cnt_col, 17); chk("f3_row", cnt_row, 6);
    reset = 1;
    tick();
    reset = 0;
    chk("mrst_busy", busy, 0); chk("mrst_col", cnt_col, 0); chk("mrst_row", cnt_row, 0);
    chk("mrst_frames", frame_cnt, 0); chk("mrst_start", ap_start, 0);
    chk("mrst_gate", pix_gate, 0); chk("mrst_cfg_rdy", cfg_ready, 1);
    tick();
    chk("mrst_no_start", ap_start, 0); chk("mrst_still_idle", busy, 0);

    // Done pulses in IDLE must not count toward the next frame.
    crop_ap_done = 1; seq_ap_done = 1;
    tick();
    crop_ap_done = 0; seq_ap_done = 0;

    // Origin x0=15 does not fit a 10-wide window in 20 columns.
    cfg_req(5'd15, 5'd2);
    chk("fit_err", cfg_err, 1);
`ifdef CROP_SEQ_CLAMP_EN
    chk("clamp_start", ap_start, 1); chk("clamp_x0", crop_x0, 10); chk("clamp_y0", crop_y0, 2);
    tick();
`else
    chk("rej_idle", busy, 0); chk("rej_no_start", ap_start, 0);
    tick();
    chk("rej_still_idle", busy, 0);
    cfg_req(5'd10, 5'd10);
    chk("edge_start", ap_start, 1); chk("edge_x0", crop_x0, 10); chk("edge_y0", crop_y0, 10);
    chk("err_sticky", cfg_err, 1);
    tick();
`endif
    chk("f4_gate", pix_gate, 1);
    stream(400, -1, -1, -1, 5'd0, 5'd0);
    tick(); tick(); tick();
    chk("f4_hold_busy", busy, 1); chk("f4_hold_frames", frame_cnt, 0);
    crop_ap_done = 1;
    tick();
    crop_ap_done = 0;
    tick();
    chk("f4_one_done", busy, 1);
    seq_ap_done = 1;
    tick();
    seq_ap_done = 0;
    tick();
    chk("f4_frames", frame_cnt, 1); chk("f4_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
